// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared types and constants for the calculator front end and
//                control unit: FSM state encoding and opcode map.
//  Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

  // Operation-select width shared with the control unit
  localparam int OPW = 3;

  // Front-end FSM state encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_WAIT_REL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_LAUNCH    = ST_LAUNCH,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_WAIT_REL  = ST_WAIT_REL
  } fe_state_t;

  typedef logic [OPW-1:0] opcode_t;

  // Opcode map understood by the control unit
  localparam opcode_t OP_ALU0  = 3'b000;
  localparam opcode_t OP_ALU1  = 3'b001;
  localparam opcode_t OP_ALU2  = 3'b010;
  localparam opcode_t OP_ALU3  = 3'b011;
  localparam opcode_t OP_DIV   = 3'b100;
  localparam opcode_t OP_MUL   = 3'b101;
  localparam opcode_t OP_SPEC0 = 3'b110;
  localparam opcode_t OP_SPEC1 = 3'b111;

endpackage
`default_nettype wire

// File: rtl/calc_go_frontend_if.sv
`default_nettype none
// ============================================================================
//  Module      : calc_go_frontend_if
//  Description : Handshake and operand bundle between the Go front end
//                (master) and the calculator control unit (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface calc_go_frontend_if #(
  parameter int W = 4
) ();
  import calc_pkg::*;

  logic           Go;
  logic           Done;
  logic [OPW-1:0] f;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           err;

  modport master (output Go, f, A, B, busy, err, input Done);
  modport slave  (input Go, f, A, B, busy, err, output Done);

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer followed by a counting debouncer. The
//                output only follows the input after it has differed for
//                DB_COUNT consecutive cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
  parameter int DB_COUNT = 500000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic btn_i,
  output logic      stable_o
);

  // DB_COUNT >= 2, so the counter is always at least one bit wide
  localparam int            CW      = $clog2(DB_COUNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

  logic          sync1_q;
  logic          btn_s_q;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          stable_q, stable_d;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      btn_s_q <= sync1_q;
    end
  end

  // Any agreement restarts the window; a full window of disagreement flips
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (btn_s_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = btn_s_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule
`default_nettype wire

// File: rtl/calc_go_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : calc_go_frontend
//  Description : Debounces the Go button, captures operation and operands on
//                a press, issues a one-cycle Go, then holds the captured values
//                until Done or timeout and waits for button release.
//  Revision    : 1.0  initial release
// ============================================================================
module calc_go_frontend
  import calc_pkg::*;
#(
  parameter int DB_COUNT = 500000,
  parameter int TIMEOUT  = 1024,
  parameter int W        = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           btn_go_i,
  input  wire logic [OPW-1:0] sw_f_i,
  input  wire logic [W-1:0]   sw_a_i,
  input  wire logic [W-1:0]   sw_b_i,
  calc_go_frontend_if.master  cu
);

  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

  logic           stable;
  logic           stable_q;
  logic           press;

  fe_state_t      state_q;
  logic           go_q;
  logic           busy_q;
  logic           err_q;
  logic [OPW-1:0] f_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [TW-1:0]  tmo_q;

  btn_debounce #(
    .DB_COUNT (DB_COUNT)
  ) u_db (
    .clk      (clk),
    .rst      (rst),
    .btn_i    (btn_go_i),
    .stable_o (stable)
  );

  // One-cycle delay of the debounced level for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable;
    end
  end

  assign press = stable & ~stable_q;

  // Launch sequencer; Go/busy are registered alongside the state they decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      f_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tmo_q   <= '0;
    end else begin
      go_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (press) begin
            f_q     <= sw_f_i;
            a_q     <= sw_a_i;
            b_q     <= sw_b_i;
            err_q   <= 1'b0;
            go_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tmo_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          tmo_q <= tmo_q + 1'b1;
          // Done takes priority over a coincident timeout
          if (cu.Done) begin
            busy_q  <= 1'b0;
            state_q <= S_WAIT_REL;
          end else if (tmo_q == TMO_MAX) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_WAIT_REL;
          end
        end
        S_WAIT_REL: begin
          // A held button must be released before another launch
          if (!stable) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cu.Go   = go_q;
  assign cu.busy = busy_q;
  assign cu.err  = err_q;
  assign cu.f    = f_q;
  assign cu.A    = a_q;
  assign cu.B    = b_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_go_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_go_frontend
//  Description : Self-checking bench for calc_go_frontend with directed
//                scenarios and randomized button/Done/switch stimulus compared
//                against a history-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_calc_go_frontend;

  localparam int DB  = 4;
  localparam int TMO = 16;
  localparam int W   = 4;

  logic         clk;
  logic         rst_r;
  logic         btn;
  logic [2:0]   swf;
  logic [W-1:0] swa;
  logic [W-1:0] swb;

  int n_checks;
  int n_pass;

  calc_go_frontend_if #(.W(W)) cu_if ();

  calc_go_frontend #(
    .DB_COUNT (DB),
    .TIMEOUT  (TMO),
    .W        (W)
  ) dut (
    .clk      (clk),
    .rst      (rst_r),
    .btn_go_i (btn),
    .sw_f_i   (swf),
    .sw_a_i   (swa),
    .sw_b_i   (swb),
    .cu       (cu_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // raw_hist[n] : button level sampled at post-reset edge n (n=0 is the reset edge)
  // st_hist[n]  : debounced level after edge n
  bit           raw_hist[$];
  bit           st_hist[$];
  int           ph;        // 0 idle, 1 launching, 2 waiting for Done, 3 waiting for release
  int           waited;
  bit           m_err;
  logic [2:0]   m_f;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;

  // Synchronized button level after edge n: two edges of delay, zero after reset
  function automatic bit bs(int n);
    if (n >= 2) return raw_hist[n-1];
    return 1'b0;
  endfunction

  task automatic model_step();
    int n;
    bit cur, prev2, flip, nst, prs;
    if (rst_r) begin
      raw_hist.delete();
      st_hist.delete();
      raw_hist.push_back(1'b0);
      st_hist.push_back(1'b0);
      ph = 0; waited = 0; m_err = 1'b0;
      m_f = '0; m_a = '0; m_b = '0;
      return;
    end
    n     = raw_hist.size();
    cur   = st_hist[n-1];
    prev2 = (n >= 2) ? st_hist[n-2] : 1'b0;
    // Level flips once the synchronized input disagreed for DB straight cycles
    flip = 1'b1;
    for (int j = 0; j < DB; j++) begin
      if ((n - 1 - j) < 0) flip = 1'b0;
      else if (bs(n - 1 - j) == cur) flip = 1'b0;
    end
    nst = flip ? ~cur : cur;
    prs = cur & ~prev2;
    case (ph)
      0: if (prs) begin
           m_f = swf; m_a = swa; m_b = swb; m_err = 1'b0; ph = 1;
         end
      1: begin ph = 2; waited = 0; end
      2: begin
           waited++;
           if (cu_if.Done) ph = 3;
           else if (waited == TMO) begin m_err = 1'b1; ph = 3; end
         end
      default: if (!cur) ph = 0;
    endcase
    raw_hist.push_back(btn);
    st_hist.push_back(nst);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic compare();
    check("Go",     32'(cu_if.Go),   32'(ph == 1));
    check("busy",   32'(cu_if.busy), 32'(ph == 1 || ph == 2));
    check("err",    32'(cu_if.err),  32'(m_err));
    check("f",      32'(cu_if.f),    32'(m_f));
    check("A",      32'(cu_if.A),    32'(m_a));
    check("B",      32'(cu_if.B),    32'(m_b));
    check("stable", 32'(dut.u_db.stable_q), 32'(st_hist[st_hist.size()-1]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    compare();
  endtask

  task automatic idle_ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int go_cnt, go_idx, busy_cnt, err_idx;
    n_checks = 0; n_pass = 0;
    rst_r = 1'b1; btn = 1'b0; swf = '0; swa = '0; swb = '0; cu_if.Done = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_go",   32'(cu_if.Go),   32'd0);
    check("rst_busy", 32'(cu_if.busy), 32'd0);
    check("rst_A",    32'(cu_if.A),    32'd0);
    rst_r = 1'b0;
    idle_ticks(3);

    // Basic press: Go exactly during the cycle after edge DB+2
    swf = 3'b101; swa = 4'h7; swb = 4'h3; btn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("go_timing", 32'(cu_if.Go), 32'(k == DB + 2));
      if (k == DB + 2) begin
        check("cap_f", 32'(cu_if.f), 32'h5);
        check("cap_A", 32'(cu_if.A), 32'h7);
        check("cap_B", 32'(cu_if.B), 32'h3);
        check("busy_with_go", 32'(cu_if.busy), 32'd1);
      end
    end
    // Done five cycles after launch, button still held
    idle_ticks(3);
    cu_if.Done = 1'b1; tick(); cu_if.Done = 1'b0;
    check("busy_after_done", 32'(cu_if.busy), 32'd0);
    swa = 4'hF;
    go_cnt = 0;
    for (int k = 0; k < 15; k++) begin tick(); if (cu_if.Go) go_cnt++; end
    check("held_no_go", 32'(go_cnt), 32'd0);
    check("A_held",     32'(cu_if.A), 32'h7);
    btn = 1'b0;
    idle_ticks(12);

    // Bounce shorter than the window never changes the level
    for (int k = 0; k < 20; k++) begin
      btn = ((k / 2) % 2 == 0);
      tick();
      check("bounce_stable", 32'(dut.u_db.stable_q), 32'd0);
      check("bounce_go",     32'(cu_if.Go), 32'd0);
    end
    btn = 1'b0;
    idle_ticks(8);

    // Timeout: never answer Done
    btn = 1'b1; go_idx = -1; err_idx = -1; busy_cnt = 0;
    for (int k = 0; k < 45; k++) begin
      if (k == 12) btn = 1'b0;
      tick();
      if (cu_if.Go && go_idx < 0) go_idx = k;
      if (cu_if.err && err_idx < 0) err_idx = k;
      if (cu_if.busy) busy_cnt++;
    end
    check("tmo_err_delay", 32'(err_idx - go_idx), 32'(TMO + 1));
    check("tmo_busy_len",  32'(busy_cnt), 32'(TMO + 1));
    check("tmo_err_set",   32'(cu_if.err), 32'd1);

    // Next launch clears err; Done coincides with the last timeout cycle
    btn = 1'b1; go_idx = -1;
    for (int k = 0; k < 20 && go_idx < 0; k++) begin
      tick();
      if (cu_if.Go) go_idx = k;
    end
    check("relaunch_seen", 32'(go_idx >= 0), 32'd1);
    check("relaunch_clr",  32'(cu_if.err), 32'd0);
    idle_ticks(TMO);
    cu_if.Done = 1'b1; tick(); cu_if.Done = 1'b0;
    check("tie_err",  32'(cu_if.err),  32'd0);
    check("tie_busy", 32'(cu_if.busy), 32'd0);
    btn = 1'b0;
    idle_ticks(12);

    // Reset during WAIT_DONE with the button held
    swf = 3'b010; swa = 4'h9; swb = 4'h4; btn = 1'b1;
    idle_ticks(DB + 3 + 3);
    check("pre_rst_busy", 32'(cu_if.busy), 32'd1);
    rst_r = 1'b1; tick(); rst_r = 1'b0;
    check("mid_rst_go",   32'(cu_if.Go),   32'd0);
    check("mid_rst_busy", 32'(cu_if.busy), 32'd0);
    check("mid_rst_A",    32'(cu_if.A),    32'd0);
    check("mid_rst_f",    32'(cu_if.f),    32'd0);
    go_cnt = 0; go_idx = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (cu_if.Go) begin go_cnt++; if (go_idx < 0) go_idx = k; end
    end
    check("post_rst_gos",   32'(go_cnt), 32'd1);
    check("post_rst_go_at", 32'(go_idx), 32'(DB + 2));
    btn = 1'b0;
    idle_ticks(12);

    // Randomized operation
    for (int it = 0; it < 60; it++) begin
      for (int r = 0; r < int'($urandom_range(0, 6)); r++) begin
        btn = 1'($urandom_range(0, 1));
        swf = 3'($urandom); swa = 4'($urandom); swb = 4'($urandom);
        tick();
      end
      btn = 1'b1;
      for (int r = 0; r < int'($urandom_range(2, 30)); r++) begin
        cu_if.Done = ($urandom_range(0, 9) == 0);
        rst_r      = ($urandom_range(0, 199) == 0);
        swf = 3'($urandom); swa = 4'($urandom); swb = 4'($urandom);
        tick();
      end
      rst_r = 1'b0;
      btn = 1'b0;
      for (int r = 0; r < int'($urandom_range(2, 25)); r++) begin
        cu_if.Done = ($urandom_range(0, 7) == 0);
        tick();
      end
      cu_if.Done = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
